// File: rtl/shift_pkg.sv
// Shared encodings for the iterative shifter: operation modes and controller states.
package shift_pkg;

  typedef enum logic [1:0] {
    MODE_SLL = 2'b00,
    MODE_SRL = 2'b01,
    MODE_SRA = 2'b10,
    MODE_ROR = 2'b11
  } shift_mode_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } shift_state_e;

endpackage

// File: rtl/shift_unit_if.sv
// Request/response bundle between a requester (master) and the shift unit (slave).
interface shift_unit_if #(
  parameter int WIDTH = 32
) ();
  localparam int SHAMT_W = $clog2(WIDTH);

  logic               start;
  logic [1:0]         mode;
  logic [SHAMT_W-1:0] shamt;
  logic [WIDTH-1:0]   din;
  logic               busy;
  logic               done;
  logic [WIDTH-1:0]   dout;

  modport master (output start, mode, shamt, din, input busy, done, dout);
  modport slave  (input start, mode, shamt, din, output busy, done, dout);
endinterface

// File: rtl/shift_step.sv
// One cycle's worth of shifting: moves the operand by k (0..STEP) positions
// in the selected direction/mode.
module shift_step
  import shift_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int STEP  = 1,
  localparam int KW   = $clog2(STEP + 1)
) (
  input  shift_mode_e      mode,
  input  logic [KW-1:0]    k,
  input  logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] y
);

  // With k=0 the left term of the rotate shifts by WIDTH and vanishes, leaving a.
  always_comb begin
    y = a;
    case (mode)
      MODE_SLL: y = a << k;
      MODE_SRL: y = a >> k;
      MODE_SRA: y = $unsigned($signed(a) >>> k);
      MODE_ROR: y = (a >> k) | (a << (WIDTH - int'(k)));
      default:  y = a;
    endcase
  end

endmodule

// File: rtl/shift_unit.sv
// Multi-cycle shifter: latches an operand on start, shifts it up to STEP bits per
// cycle until the requested amount is consumed, then pulses done for one cycle.
module shift_unit
  import shift_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int STEP  = 1
) (
  input  logic        clk,
  input  logic        reset,
  shift_unit_if.slave bus
);

  localparam int SHAMT_W = $clog2(WIDTH);
  localparam int KW      = $clog2(STEP + 1);
  localparam logic [SHAMT_W-1:0] STEP_CNT = SHAMT_W'(STEP);
  localparam logic [KW-1:0]      STEP_K   = KW'(STEP);

  shift_state_e       state;
  shift_mode_e        mode_q;
  logic [WIDTH-1:0]   acc;
  logic [WIDTH-1:0]   step_out;
  logic [SHAMT_W-1:0] cnt;
  logic [SHAMT_W-1:0] cnt_next;
  logic [KW-1:0]      k;
  logic               busy_q;
  logic               done_q;

  // The last step may be shorter than STEP when the remaining count is smaller.
  always_comb begin
    k        = (cnt < STEP_CNT) ? cnt[KW-1:0] : STEP_K;
    cnt_next = cnt - SHAMT_W'(k);
  end

  shift_step #(
    .WIDTH(WIDTH),
    .STEP (STEP)
  ) u_step (
    .mode(mode_q),
    .k   (k),
    .a   (acc),
    .y   (step_out)
  );

  // busy and done are registered alongside the state so they change only on edges.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= ST_IDLE;
      mode_q <= MODE_SLL;
      acc    <= '0;
      cnt    <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          done_q <= 1'b0;
          if (bus.start) begin
            acc    <= bus.din;
            cnt    <= bus.shamt;
            mode_q <= shift_mode_e'(bus.mode);
            busy_q <= 1'b1;
            if (bus.shamt != '0) begin
              state <= ST_SHIFT;
            end else begin
              state  <= ST_DONE;
              done_q <= 1'b1;
            end
          end
        end
        ST_SHIFT: begin
          acc <= step_out;
          cnt <= cnt_next;
          if (cnt_next == '0) begin
            state  <= ST_DONE;
            done_q <= 1'b1;
          end
        end
        ST_DONE: begin
          state  <= ST_IDLE;
          busy_q <= 1'b0;
          done_q <= 1'b0;
        end
        default: begin
          state  <= ST_IDLE;
          busy_q <= 1'b0;
          done_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.dout = acc;

endmodule

// File: doc/shift_unit.md
SHIFT_UNIT -- requirements
Module: shift_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 32: datapath width in bits; power of two, at least 8.
REQ-002 SHALL have parameter STEP, default 1: maximum bit positions shifted per cycle; power of two, at most WIDTH/2.
REQ-003 SHALL have derived localparam SHAMT_W = $clog2(WIDTH): shift-amount width.
REQ-004 SHALL use one clock and an asynchronous, active-high reset; no other clock or reset.
REQ-005 SHALL have port clk, input, 1: rising-edge clock.
REQ-006 SHALL have port reset, input, 1: asynchronous active-high reset.
REQ-007 SHALL have port start, input, 1: request; sampled only in IDLE.
REQ-008 SHALL have port mode, input, 2: 00 SLL, 01 SRL, 10 SRA, 11 ROR; sampled with start.
REQ-009 SHALL have port shamt, input, SHAMT_W: shift amount, 0..WIDTH-1; sampled with start.
REQ-010 SHALL have port din, input, WIDTH: operand; sampled with start.
REQ-011 SHALL have port busy, output, 1: high in SHIFT and DONE.
REQ-012 SHALL have port done, output, 1: one-cycle pulse when the result is final.
REQ-013 SHALL have port dout, output, WIDTH: result register; always equals the internal accumulator.

Function
REQ-014 SHALL implement the state machine IDLE, SHIFT, DONE with registered state.
REQ-015 On a rising edge in IDLE with start=1: acc<=din, cnt<=shamt, mode latched; next state SHIFT if shamt!=0, else DONE.
REQ-016 In SHIFT, each edge: k=min(STEP,cnt); acc shifted by k per the latched mode; cnt<=cnt-k; next state DONE when cnt-k==0, else stay in SHIFT.
REQ-017 SLL SHALL zero-fill LSBs; SRL SHALL zero-fill MSBs; SRA SHALL replicate acc[WIDTH-1]; ROR SHALL move the bits shifted out of the LSB into the MSB.
REQ-018 In DONE: done=1 for exactly one cycle; next state IDLE unconditionally.
REQ-019 Latency: done SHALL be high in the cycle following edge 1+ceil(shamt/STEP) after the start-sampling edge; shamt=0 gives done one cycle after start, with dout=din.
REQ-020 start, mode, shamt and din SHALL be ignored while busy=1; no queuing.
REQ-021 start=1 in the same cycle as done=1 SHALL be ignored; a new request SHALL be accepted only from IDLE.
REQ-022 dout SHALL hold its last value in IDLE until the next accepted start.
REQ-023 Intermediate dout values during SHIFT are not architecturally valid; consumers SHALL sample only on done.

Reset
REQ-024 Reset SHALL force state=IDLE, acc=0, cnt=0, latched mode=00 immediately, with no dependence on clk.
REQ-025 Outputs in reset: busy=0, done=0, dout=0.
REQ-026 Reset asserted mid-operation SHALL abort the operation with no done pulse; the first start after deassertion SHALL be accepted normally.

Structure
REQ-027 Mode encodings (SLL/SRL/SRA/ROR) and state encodings SHALL live in the shared package shift_pkg.
REQ-028 The per-cycle combinational shift by k (0..STEP) under a given mode SHALL be a sub-module, shift_step, parameterised by WIDTH and STEP.
REQ-029 shift_unit SHALL contain only the FSM, counter and accumulator registers, plus one shift_step instance.

Verification
REQ-030 WIDTH=32, STEP=1: din=0x00000001, SLL, shamt=2 -> dout=0x00000004; done pulses 3 cycles after start; busy high for 3 cycles.
REQ-031 STEP=1: din=0x80000000, SRA, shamt=4 -> 0xF8000000; same din with SRL, shamt=4 -> 0x08000000.
REQ-032 STEP=4: din=0x80000000, SRL, shamt=31 -> 0x00000001 with done 9 cycles after start; ROR din=0x00000001, shamt=1 -> 0x80000000.
REQ-033 shamt=0, din=0xDEADBEEF, any mode -> dout=0xDEADBEEF, done one cycle after start; start held high continuously is accepted only in IDLE, yielding back-to-back operations with one idle cycle between them.
REQ-034 Reset asserted 2 cycles into SLL shamt=20 -> busy=0, dout=0 immediately, no done; a following SLL of din=0x3 by 1 -> 0x6.
